exec_issue_ctrl: RTL and testbench
==================================

# exec_issue_ctrl

Issue controller and two-way arbiter in front of the execute stage. Accepts operation requests from two requesters, the scalar issue path (id 0) and the vector issue path (id 1), and grants one at a time round-robin. It registers the winner's opcode and operands onto the execute-stage inputs, captures the result class selected by the opcode, and returns it through a valid/ready response channel tagged with the requester id.

## Interface
- SW, 21: scalar operand, immediate and scalar result width.
- VW, 192: vector operand and result width.
- NREQ, 2: requester count; fixed at 2 and not to be overridden.
- clk  in  1  single clock; all state is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  [NREQ-1:0]  request valid per requester.
- req_ready  out  [NREQ-1:0]  request accepted per requester; one-hot or zero.
- req_exc  in  [NREQ-1:0][4:0]  opcode; bit 0 selects the immediate as the second scalar operand.
- req_r1e, req_r2e, req_imm  in  [NREQ-1:0][SW-1:0]  scalar operands and immediate.
- req_r1v, req_r2v  in  [NREQ-1:0][VW-1:0]  vector operands.
- ex_exc  out  5  execute-stage opcode, registered.
- ex_r1e, ex_r2e, ex_imm  out  SW  execute-stage scalar inputs, registered.
- ex_r1v, ex_r2v  out  VW  execute-stage vector inputs, registered.
- ex_res_alue  in  SW  scalar ALU result (combinational from ex_*).
- ex_res_aluve  in  VW  vector-scalar result.
- ex_res_sum  in  VW  vector-vector result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  1  id of the requester that issued the operation.
- rsp_class  out  2  operation class.
- rsp_err  out  1  the opcode was illegal.
- rsp_scalar  out  SW  scalar result.
- rsp_vector  out  VW  vector result.

## Operation
- The opcode class is exc[4:3]:
  - 00 scalar: result is ex_res_alue, placed on rsp_scalar.
  - 01 vector-scalar: result is ex_res_aluve, placed on rsp_vector.
  - 10 vector-vector: result is ex_res_sum, placed on rsp_vector.
  - 11 illegal: rsp_err=1.
- The result bus not used by the class is driven to 0. An illegal opcode returns both result buses as 0.
- The FSM has three states:
  - IDLE: req_ready is asserted only here, one-hot to the arbitration winner with a valid request. On a handshake, capture the winner's fields into the ex_* registers, latch the id, and go to EXEC.
  - EXEC: capture the class-selected result, class, err and id into the rsp registers, then go to RESP. The ex_* registers hold.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE.
- Arbitration is round-robin. A last_grant register (reset 1) selects the winner when both requesters are valid: the winner is !last_grant. A lone valid requester always wins. last_grant updates only on a handshake.
- ex_* outputs keep their last issued values until the next grant; they are never cleared between operations.
- A requester may drop req_valid at any time before its handshake; no state change results.
- Asserting rsp_ready while rsp_valid=0 has no effect.

## Timing
- Request handshake in cycle T. ex_* are valid from T+1. The result is sampled at the end of T+1. rsp_valid rises at T+2.
- If rsp_ready=1 at T+2, the FSM is in IDLE at T+3 and the next handshake can occur in T+3. Peak throughput is 1 operation per 3 cycles.
- Under rsp_ready=0, all rsp_* outputs hold stable until the handshake.
- Reset (async assert, any state):
  - state=IDLE, last_grant=1.
  - req_ready=0, rsp_valid=0.
  - All ex_* and rsp_* outputs are 0.
  - Any in-flight operation is dropped; no response is produced for it.
- After reset deassertion, the first grant can occur on the first rising edge.

## Structure
- Shared package exec_pkg: the exc_class_e enum (CLS_SCALAR=2'b00, CLS_VS=2'b01, CLS_VV=2'b10, CLS_ILL=2'b11), the SW/VW constants, and a state enum (S_IDLE, S_EXEC, S_RESP).
- One sub-module, rr_arb2: a two-input round-robin arbiter with a last-grant register. It outputs a one-hot grant and advances on an accept input.
- The operand capture muxes, result select and FSM live in the top module.

## Test plan
- Single scalar request: req_valid=2'b01, exc=5'b00001, r1e=5, imm=3, with a model execute stage returning 8. Required: req_ready[0] at T, ex_imm=3 at T+1, then at T+2 rsp_valid=1, rsp_id=0, rsp_class=00, rsp_scalar=8, rsp_vector=0.
- Contention: both requesters valid continuously, rsp_ready=1. Required grant order after reset is 0,1,0,1, with handshakes at T, T+3, T+6, T+9.
- Backpressure: vector-vector request (exc=5'b10000) with ex_res_sum=all 0xA5 bytes, rsp_ready held 0 for 5 cycles. Required: rsp_valid and rsp_vector stay stable, req_ready=2'b00 throughout, and the FSM returns to IDLE the cycle after rsp_ready rises.
- Illegal opcode: exc=5'b11000. Required: rsp_err=1, rsp_class=11, rsp_scalar=0, rsp_vector=0.
- Reset mid-operation: rst_n pulsed low during EXEC. Required: outputs go to 0 asynchronously, no response is produced, and the next grant goes to requester 0 when both are valid.
- Withdrawn request: req_valid[1] pulsed for one cycle while the FSM is in RESP. Required: no grant, and last_grant is unchanged.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage issue controller.
package exec_pkg;

    localparam int SW   = 21;
    localparam int VW   = 192;
    localparam int NREQ = 2;

    // Result class carried in opcode bits [4:3].
    typedef enum logic [1:0] {
        CLS_SCALAR = 2'b00,
        CLS_VS     = 2'b01,
        CLS_VV     = 2'b10,
        CLS_ILL    = 2'b11
    } exc_class_e;

    // Issue FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    function automatic exc_class_e exc_class(input logic [4:0] exc);
        return exc_class_e'(exc[4:3]);
    endfunction

endpackage

// File: rtl/exec_issue_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; when both
// request, the one that was not granted last wins. The last-grant register
// only moves when the caller reports an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant from the current requests and the last winner.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner of each accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue controller for the execute stage: arbitrates two requesters,
// registers the winner's operands onto the execute inputs, captures the
// class-selected result and returns it on a valid/ready response channel.
module exec_issue_ctrl
    import exec_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][4:0]      req_exc,
    input  logic [NREQ-1:0][SW-1:0]   req_r1e,
    input  logic [NREQ-1:0][SW-1:0]   req_r2e,
    input  logic [NREQ-1:0][SW-1:0]   req_imm,
    input  logic [NREQ-1:0][VW-1:0]   req_r1v,
    input  logic [NREQ-1:0][VW-1:0]   req_r2v,
    output logic [4:0]                ex_exc,
    output logic [SW-1:0]             ex_r1e,
    output logic [SW-1:0]             ex_r2e,
    output logic [SW-1:0]             ex_imm,
    output logic [VW-1:0]             ex_r1v,
    output logic [VW-1:0]             ex_r2v,
    input  logic [SW-1:0]             ex_res_alue,
    input  logic [VW-1:0]             ex_res_aluve,
    input  logic [VW-1:0]             ex_res_sum,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [1:0]                rsp_class,
    output logic                      rsp_err,
    output logic [SW-1:0]             rsp_scalar,
    output logic [VW-1:0]             rsp_vector
);

    state_e      state;
    logic [1:0]  grant;
    logic        win_id;
    logic        id_reg;
    logic        hs;
    exc_class_e  cls;
    logic [SW-1:0] sel_scalar;
    logic [VW-1:0] sel_vector;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (hs),
        .grant  (grant)
    );

    assign win_id = grant[1];
    assign hs     = |(req_valid & req_ready);
    assign cls    = exc_class(ex_exc);

    // Offer the arbitration winner a handshake only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if ((state == S_IDLE) && rst_n) begin
            req_ready = grant;
        end
    end

    // Route the execute result for this class; unused buses read as zero.
    always_comb begin
        sel_scalar = '0;
        sel_vector = '0;
        case (cls)
            CLS_SCALAR: sel_scalar = ex_res_alue;
            CLS_VS:     sel_vector = ex_res_aluve;
            CLS_VV:     sel_vector = ex_res_sum;
            default:    ;
        endcase
    end

    // Issue FSM with operand capture and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            id_reg     <= 1'b0;
            ex_exc     <= '0;
            ex_r1e     <= '0;
            ex_r2e     <= '0;
            ex_imm     <= '0;
            ex_r1v     <= '0;
            ex_r2v     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_class  <= '0;
            rsp_err    <= 1'b0;
            rsp_scalar <= '0;
            rsp_vector <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        ex_exc <= req_exc[win_id];
                        ex_r1e <= req_r1e[win_id];
                        // Opcode bit 0 substitutes the immediate for the second scalar operand.
                        ex_r2e <= req_exc[win_id][0] ? req_imm[win_id] : req_r2e[win_id];
                        ex_imm <= req_imm[win_id];
                        ex_r1v <= req_r1v[win_id];
                        ex_r2v <= req_r2v[win_id];
                        id_reg <= win_id;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_id     <= id_reg;
                    rsp_class  <= cls;
                    rsp_err    <= (cls == CLS_ILL);
                    rsp_scalar <= sel_scalar;
                    rsp_vector <= sel_vector;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Self-checking bench for exec_issue_ctrl: directed scenarios plus random
// operations checked against a request-level reference model.
module tb_exec_issue_ctrl;
    import exec_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][4:0]    req_exc;
    logic [NREQ-1:0][SW-1:0] req_r1e, req_r2e, req_imm;
    logic [NREQ-1:0][VW-1:0] req_r1v, req_r2v;
    logic [4:0]              ex_exc;
    logic [SW-1:0]           ex_r1e, ex_r2e, ex_imm;
    logic [VW-1:0]           ex_r1v, ex_r2v;
    logic [SW-1:0]           ex_res_alue;
    logic [VW-1:0]           ex_res_aluve, ex_res_sum;
    logic                    rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [1:0]              rsp_class;
    logic [SW-1:0]           rsp_scalar;
    logic [VW-1:0]           rsp_vector;

    int  tests = 0;
    int  fails = 0;
    int  lg    = 1;       // model of the round-robin last winner
    bit  force_a5 = 1'b0;
    logic [VW-1:0] a5_pat;

    always #5 clk = ~clk;

    // Environment execute stage.
    assign ex_res_alue  = ex_r1e + ex_r2e;
    assign ex_res_aluve = ex_r1v + {{(VW-SW){1'b0}}, ex_r2e};
    assign ex_res_sum   = force_a5 ? a5_pat : (ex_r1v + ex_r2v);

    exec_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_exc(req_exc), .req_r1e(req_r1e), .req_r2e(req_r2e), .req_imm(req_imm),
        .req_r1v(req_r1v), .req_r2v(req_r2v),
        .ex_exc(ex_exc), .ex_r1e(ex_r1e), .ex_r2e(ex_r2e), .ex_imm(ex_imm),
        .ex_r1v(ex_r1v), .ex_r2v(ex_r2v),
        .ex_res_alue(ex_res_alue), .ex_res_aluve(ex_res_aluve), .ex_res_sum(ex_res_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_class(rsp_class), .rsp_err(rsp_err),
        .rsp_scalar(rsp_scalar), .rsp_vector(rsp_vector)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_v();
        logic [VW-1:0] v;
        for (int k = 0; k < VW/32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic int winner(input logic [1:0] vm);
        if (vm == 2'b11) return (lg == 1) ? 0 : 1;
        return vm[0] ? 0 : 1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < NREQ; i++) begin
            req_exc[i] = 5'($urandom);
            req_r1e[i] = SW'($urandom);
            req_r2e[i] = SW'($urandom);
            req_imm[i] = SW'($urandom);
            req_r1v[i] = rand_v();
            req_r2v[i] = rand_v();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation starting in IDLE at posedge+1.
    task automatic run_op(input logic [1:0] vm, input int bp, input bit poke);
        int w;
        logic [4:0]    e;
        logic [1:0]    c;
        logic [SW-1:0] r1, r2, im, es;
        logic [VW-1:0] v1, v2, ev;
        req_valid = vm;
        #1;
        w  = winner(vm);
        e  = req_exc[w];
        r1 = req_r1e[w];
        im = req_imm[w];
        r2 = e[0] ? im : req_r2e[w];
        v1 = req_r1v[w];
        v2 = req_r2v[w];
        c  = e[4:3];
        es = '0;
        ev = '0;
        if (c == 2'b00) es = r1 + r2;
        if (c == 2'b01) ev = v1 + {{(VW-SW){1'b0}}, r2};
        if (c == 2'b10) ev = force_a5 ? a5_pat : (v1 + v2);
        chk("req_ready_grant", VW'(req_ready), VW'(2'b01 << w));
        step();
        lg = w;
        req_valid = '0;
        chk("ex_exc", VW'(ex_exc), VW'(e));
        chk("ex_r1e", VW'(ex_r1e), VW'(r1));
        chk("ex_r2e", VW'(ex_r2e), VW'(r2));
        chk("ex_imm", VW'(ex_imm), VW'(im));
        chk("ex_r1v", ex_r1v, v1);
        chk("ex_r2v", ex_r2v, v2);
        chk("rsp_valid_exec", VW'(rsp_valid), VW'(1'b0));
        step();
        for (int b = 0; b <= bp; b++) begin
            if (poke && b < bp) req_valid = 2'b10;
            #1;
            chk("rsp_valid", VW'(rsp_valid), VW'(1'b1));
            chk("rsp_id", VW'(rsp_id), VW'(w));
            chk("rsp_class", VW'(rsp_class), VW'(c));
            chk("rsp_err", VW'(rsp_err), VW'(c == 2'b11));
            chk("rsp_scalar", VW'(rsp_scalar), VW'(es));
            chk("rsp_vector", rsp_vector, ev);
            chk("req_ready_busy", VW'(req_ready), VW'(2'b00));
            if (b == bp) rsp_ready = 1'b1;
            step();
            req_valid = '0;
        end
        rsp_ready = 1'b0;
        chk("rsp_valid_done", VW'(rsp_valid), VW'(1'b0));
        $display("[TB] op vm=%b winner=%0d exc=%b class=%0d bp=%0d", vm, w, e, c, bp);
    endtask

    initial begin
        for (int k = 0; k < VW/8; k++) a5_pat[8*k +: 8] = 8'hA5;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        rand_fields();
        step();
        step();
        chk("rst_req_ready", VW'(req_ready), VW'(2'b00));
        chk("rst_rsp_valid", VW'(rsp_valid), VW'(1'b0));
        chk("rst_ex_exc", VW'(ex_exc), '0);
        chk("rst_ex_r1v", ex_r1v, '0);
        chk("rst_rsp_vector", rsp_vector, '0);
        rst_n = 1'b1;
        lg = 1;

        // Contention: both valid, rsp_ready high; grants every third cycle, alternating.
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (cyc % 3 == 0) begin
                chk("contend_grant", VW'(req_ready), VW'(2'b01 << winner(2'b11)));
                chk("contend_order", VW'(req_ready[1]), VW'((cyc / 3) % 2));
                lg = winner(2'b11);
            end else begin
                chk("contend_gap", VW'(req_ready), VW'(2'b00));
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        $display("[TB] contention sequence done");

        // Single scalar request with immediate: 5 + 3 = 8.
        req_exc[0] = 5'b00001;
        req_r1e[0] = 21'd5;
        req_imm[0] = 21'd3;
        run_op(2'b01, 0, 1'b0);

        // Vector-vector under backpressure with a fixed 0xA5 result.
        force_a5 = 1'b1;
        req_exc[1] = 5'b10000;
        run_op(2'b10, 5, 1'b0);
        force_a5 = 1'b0;

        // Illegal opcode.
        req_exc[0] = 5'b11000;
        run_op(2'b01, 0, 1'b0);

        // Withdrawn request pulses during RESP; arbitration must not move.
        rand_fields();
        run_op(2'b01, 3, 1'b1);
        rand_fields();
        run_op(2'b11, 0, 1'b0);

        // Random operations.
        for (int n = 0; n < 24; n++) begin
            rand_fields();
            run_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1'($urandom));
        end

        // Reset mid-operation (during EXEC).
        rand_fields();
        req_valid = 2'b11;
        step();
        lg = winner(2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ex_exc", VW'(ex_exc), '0);
        chk("mid_rst_ex_r1e", VW'(ex_r1e), '0);
        chk("mid_rst_ex_r2v", ex_r2v, '0);
        chk("mid_rst_req_ready", VW'(req_ready), VW'(2'b00));
        chk("mid_rst_rsp_valid", VW'(rsp_valid), VW'(1'b0));
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        lg = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_rsp", VW'(rsp_valid), VW'(1'b0));
        end
        rsp_ready = 1'b0;
        rand_fields();
        run_op(2'b11, 0, 1'b0);
        chk("post_rst_first_winner", VW'(lg), VW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
